// File: rtl/seg7_pkg.sv
// Shared definitions for the seven-segment encoder / readback pair.
// Holds the active-low hex segment patterns (bit 6 = g ... bit 0 = a), the blank pattern,
// the readback frame FSM encoding and the upper bound on multiplexed digit positions.
package seg7_pkg;

  localparam int unsigned DigitsMax = 8;

  localparam logic [6:0] SegHex0  = 7'h40;
  localparam logic [6:0] SegHex1  = 7'h79;
  localparam logic [6:0] SegHex2  = 7'h24;
  localparam logic [6:0] SegHex3  = 7'h30;
  localparam logic [6:0] SegHex4  = 7'h19;
  localparam logic [6:0] SegHex5  = 7'h12;
  localparam logic [6:0] SegHex6  = 7'h02;
  localparam logic [6:0] SegHex7  = 7'h78;
  localparam logic [6:0] SegHex8  = 7'h00;
  localparam logic [6:0] SegHex9  = 7'h18;
  localparam logic [6:0] SegHexA  = 7'h08;
  localparam logic [6:0] SegHexB  = 7'h03;
  localparam logic [6:0] SegHexC  = 7'h46;
  localparam logic [6:0] SegHexD  = 7'h21;
  localparam logic [6:0] SegHexE  = 7'h06;
  localparam logic [6:0] SegHexF  = 7'h0E;
  localparam logic [6:0] SegBlank = 7'h7F;

  // Frame FSM encoding
  localparam logic [0:0] StCollect = 1'b0;
  localparam logic [0:0] StHold    = 1'b1;

  function automatic logic [6:0] seg_of_hex(input logic [3:0] h);
    logic [6:0] p;
    case (h)
      4'h0:    p = SegHex0;
      4'h1:    p = SegHex1;
      4'h2:    p = SegHex2;
      4'h3:    p = SegHex3;
      4'h4:    p = SegHex4;
      4'h5:    p = SegHex5;
      4'h6:    p = SegHex6;
      4'h7:    p = SegHex7;
      4'h8:    p = SegHex8;
      4'h9:    p = SegHex9;
      4'hA:    p = SegHexA;
      4'hB:    p = SegHexB;
      4'hC:    p = SegHexC;
      4'hD:    p = SegHexD;
      4'hE:    p = SegHexE;
      default: p = SegHexF;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the hex-to-seven-segment encoder.
// Ports:
//   pat_i     7-bit active-low segment pattern
//   nibble_o  decoded hex value (0 for blank or unrecognised patterns)
//   blank_o   pattern is all segments off
//   err_o     pattern is neither a hex glyph nor blank
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat_i,
  output logic [3:0] nibble_o,
  output logic       blank_o,
  output logic       err_o
);

  always_comb begin
    nibble_o = 4'h0;
    blank_o  = (pat_i == SegBlank);
    err_o    = (pat_i != SegBlank);
    for (int unsigned h = 0; h < 16; h++) begin
      if (pat_i == seg_of_hex(4'(h))) begin
        nibble_o = 4'(h);
        err_o    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_readback.sv
// Seven-segment display readback.
// Samples a multiplexed active-low display bus, waits for each digit position to show the
// same pattern for STABLE_CYCLES consecutive samples, decodes it, and presents a complete
// frame of DIGITS positions on a valid/ready interface.
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   seg_n             segment lines, active-low, bit 6 = g ... bit 0 = a
//   an_n              anode strobes, active-low, legal only when exactly one is low
//   out_value         digit i in bits [4i+3:4i]
//   out_blank         digit i showed all segments off
//   out_err           digit i showed an unrecognised pattern
//   out_valid         frame available; held with data until out_ready is sampled high
//   out_ready         consumer accepts the frame
// Build option SEG7_READBACK_DP_EN adds dp_n (active-low decimal point, part of the stability
// comparison) and out_dp (captured decimal point per digit).
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,  // 1..DigitsMax
  parameter int unsigned STABLE_CYCLES = 8   // 2..255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [6:0]            seg_n,
  input  logic [DIGITS-1:0]     an_n,
`ifdef SEG7_READBACK_DP_EN
  input  logic                  dp_n,
  output logic [DIGITS-1:0]     out_dp,
`endif
  output logic [4*DIGITS-1:0]   out_value,
  output logic [DIGITS-1:0]     out_blank,
  output logic [DIGITS-1:0]     out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam logic [7:0] StableMax  = 8'(STABLE_CYCLES);
  localparam logic [7:0] StableLast = 8'(STABLE_CYCLES - 1);

  // Stability tracker
  logic [DIGITS-1:0] prev_an_q, prev_an_d;
  logic [6:0]        prev_seg_q, prev_seg_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              hit_q, hit_d;
  logic [DIGITS-1:0] an_low;
  logic              legal, same;

  // Working slots and frame state
  logic [4*DIGITS-1:0] work_val_q, work_val_d;
  logic [DIGITS-1:0]   work_blank_q, work_blank_d;
  logic [DIGITS-1:0]   work_err_q, work_err_d;
  logic [DIGITS-1:0]   seen_q, seen_d;
  logic [DIGITS-1:0]   commit_mask;
  logic [0:0]          state_q, state_d;
  logic                snap, xfer;

  logic [4*DIGITS-1:0] out_val_q;
  logic [DIGITS-1:0]   out_blank_q, out_err_q;

  logic [3:0] dec_nibble;
  logic       dec_blank, dec_err;

`ifdef SEG7_READBACK_DP_EN
  logic              prev_dp_q, prev_dp_d;
  logic [DIGITS-1:0] work_dp_q, work_dp_d;
  logic [DIGITS-1:0] out_dp_q;
`endif

  always_comb begin
    an_low = ~an_n;
    legal  = (an_low != '0) && ((an_low & (an_low - DIGITS'(1))) == '0);
    same   = (an_n == prev_an_q) && (seg_n == prev_seg_q);
`ifdef SEG7_READBACK_DP_EN
    same   = same && (dp_n == prev_dp_q);
    prev_dp_d = prev_dp_q;
`endif
    prev_an_d  = prev_an_q;
    prev_seg_d = prev_seg_q;
    cnt_d      = cnt_q;
    hit_d      = 1'b0;
    if (!legal) begin
      cnt_d = '0;
    end else if (same) begin
      if (cnt_q < StableMax) begin
        cnt_d = cnt_q + 8'd1;
      end
      // Fires only on the step into saturation, so a held pattern commits once.
      hit_d = (cnt_q == StableLast);
    end else begin
      prev_an_d  = an_n;
      prev_seg_d = seg_n;
`ifdef SEG7_READBACK_DP_EN
      prev_dp_d  = dp_n;
`endif
      cnt_d      = 8'd1;
    end
  end

  // The registered sample is always legal, so its inverted anode is a one-hot digit select.
  seg7_pattern_decode u_decode (
    .pat_i    (prev_seg_q),
    .nibble_o (dec_nibble),
    .blank_o  (dec_blank),
    .err_o    (dec_err)
  );

  always_comb begin
    commit_mask  = hit_q ? ~prev_an_q : '0;
    work_val_d   = work_val_q;
    work_blank_d = work_blank_q;
    work_err_d   = work_err_q;
`ifdef SEG7_READBACK_DP_EN
    work_dp_d    = work_dp_q;
`endif
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (commit_mask[i]) begin
        work_val_d[4*i +: 4] = dec_nibble;
        work_blank_d[i]      = dec_blank;
        work_err_d[i]        = dec_err;
`ifdef SEG7_READBACK_DP_EN
        work_dp_d[i]         = ~prev_dp_q;
`endif
      end
    end
  end

  always_comb begin
    snap    = (state_q == StCollect) && (&seen_q);
    xfer    = (state_q == StHold) && out_ready;
    state_d = state_q;
    if (snap) begin
      state_d = StHold;
    end else if (xfer) begin
      state_d = StCollect;
    end
    // A same-cycle commit survives the snapshot clear and counts toward the next frame.
    seen_d = (snap ? '0 : seen_q) | commit_mask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_an_q    <= '1;
      prev_seg_q   <= SegBlank;
      cnt_q        <= '0;
      hit_q        <= 1'b0;
      work_val_q   <= '0;
      work_blank_q <= '0;
      work_err_q   <= '0;
      seen_q       <= '0;
      state_q      <= StCollect;
      out_val_q    <= '0;
      out_blank_q  <= '0;
      out_err_q    <= '0;
`ifdef SEG7_READBACK_DP_EN
      prev_dp_q    <= 1'b1;
      work_dp_q    <= '0;
      out_dp_q     <= '0;
`endif
    end else begin
      prev_an_q    <= prev_an_d;
      prev_seg_q   <= prev_seg_d;
      cnt_q        <= cnt_d;
      hit_q        <= hit_d;
      work_val_q   <= work_val_d;
      work_blank_q <= work_blank_d;
      work_err_q   <= work_err_d;
      seen_q       <= seen_d;
      state_q      <= state_d;
`ifdef SEG7_READBACK_DP_EN
      prev_dp_q    <= prev_dp_d;
      work_dp_q    <= work_dp_d;
`endif
      if (snap) begin
        out_val_q   <= work_val_q;
        out_blank_q <= work_blank_q;
        out_err_q   <= work_err_q;
`ifdef SEG7_READBACK_DP_EN
        out_dp_q    <= work_dp_q;
`endif
      end
    end
  end

  assign out_value = out_val_q;
  assign out_blank = out_blank_q;
  assign out_err   = out_err_q;
  assign out_valid = (state_q == StHold);
`ifdef SEG7_READBACK_DP_EN
  assign out_dp    = out_dp_q;
`endif

endmodule

// File: doc/seg7_readback.md
# seg7_readback

Receive-side counterpart of the hex-to-seven-segment encoder. It samples a multiplexed, active-low seven-segment display bus (segment lines plus anode strobes) and reconstructs the hex digit shown in each position, with blank and error flags per digit. Complete frames go to a valid/ready consumer. It sits beside the display driver as a self-check and readback path for on-board test.

## Interface
- DIGITS, 4: number of multiplexed digit positions (1..8)
- STABLE_CYCLES, 8: consecutive identical samples required before a digit is committed (2..255)
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- seg_n  in  7  segment lines, active-low; bit 6 = g … bit 0 = a
- an_n  in  DIGITS  anode strobes, active-low, one-hot when legal
- out_value  out  4*DIGITS  digit i in bits [4i+3:4i]
- out_blank  out  DIGITS  digit i showed all-segments-off
- out_err  out  DIGITS  digit i showed a non-hex, non-blank pattern
- out_valid  out  1  frame available
- out_ready  in  1  consumer accepts frame

## Operation
- Decode table, seg_n to nibble: 40→0, 79→1, 24→2, 30→3, 19→4, 12→5, 02→6, 78→7, 00→8, 18→9, 08→A, 03→B, 46→C, 21→D, 06→E, 0E→F. 7F means blank (nibble 0). Any other pattern is an error (nibble 0).
- Legal sample: an_n has exactly one bit low. Zero or multiple low bits are illegal. An illegal sample clears the stability counter and commits nothing.
- Stability tracker: registers the previous (an_n, seg_n) pair and a counter of 8 bits. If the legal sample equals the previous one, the counter increments and saturates at STABLE_CYCLES. Otherwise it reloads to 1.
- Commit: on the cycle the counter reaches STABLE_CYCLES, the decoded nibble, blank and err are written to that digit's working slot and its seen bit is set. A digit commits once per stable run and again only after the pattern or anode changes.
- Frame FSM, states COLLECT and HOLD:
  - COLLECT → HOLD when all seen bits are set and no frame is pending. The working slots are copied to the out_* registers and the seen bits are cleared.
  - HOLD → COLLECT on out_valid && out_ready.
  - Collection continues in HOLD. The working slots keep updating. If all seen bits are set again while still in HOLD, the frame waits; it is not dropped and the outputs do not change.
- A commit and a frame snapshot in the same cycle: the snapshot takes the pre-commit working slot. The commit still sets its seen bit for the next frame.

## Timing
- Reset values: out_value 0, out_blank 0, out_err 0, out_valid 0, all seen bits 0, counter 0, FSM in COLLECT.
- Commit latency: the sample that makes the STABLE_CYCLES-th identical occurrence is registered, and the slot updates on the following edge.
- out_valid rises one cycle after the last missing digit commits.
- Handshake:
  - out_valid stays high, and out_* stay stable, until out_ready is sampled high.
  - out_valid falls on the next edge.
  - A pending frame can reassert out_valid at the earliest one cycle after the transfer.
- out_ready is ignored while out_valid is low.
- rst asserted mid-frame or mid-handshake: on the next edge everything returns to reset values and any partial frame is discarded.

## Configuration
- SEG7_READBACK_DP_EN:
  - Defined: adds input dp_n (1 bit, active-low decimal point) and output out_dp (DIGITS bits, reset 0). dp_n is part of the stability comparison and is captured per digit.
  - Undefined: neither port exists, and dp activity has no effect.

## Structure
- Shared package seg7_pkg holds:
  - the 16 hex segment constants and the blank constant (7F), shared with the encoder
  - the FSM state encoding
  - the DIGITS upper bound
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern in; nibble, blank and err out. Instantiated once on the registered sample.

## Test plan
- DIGITS=4, STABLE_CYCLES=8. Scan digits 0..3 showing 12, 24, 30, 79 (5, 2, 3, 1) for 10 cycles each, out_ready=1 → out_value=16'h1325, out_blank=0, out_err=0, one out_valid pulse.
- Digit 1 held at 7F, digit 2 held at 55 → out_blank=4'b0010, out_err=4'b0100, with digits 1 and 2 at nibble 0.
- Digit 0 held for only 7 cycles per scan → that digit never commits and out_valid never asserts.
- Two frames completed while out_ready=0 → out_valid stays high with the first frame unchanged. On out_ready, the first frame transfers, then the second appears with out_valid reasserted one cycle later.
- an_n=4'b0101 (two anodes low) between legal scans → no commit. The stability counter restarts and the result matches a clean scan.
- rst pulsed after three digits commit → all outputs are 0. Completing a full scan afterwards is required before out_valid asserts.
